// File: rtl/mmu_arbiter_pkg.sv
// Shared types and constants for the core-to-backend memory arbiter.
package mmu_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_W = 3'd1,
    SERVE_D = 3'd2,
    SERVE_I = 3'd3,
    DONE    = 3'd4
  } arb_state_t;

  localparam int NUM_SRC = 3;
  localparam int SRC_W   = 0;
  localparam int SRC_D   = 1;
  localparam int SRC_I   = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

endpackage

// File: rtl/mmu_arbiter_slot.sv
// One pending-request register: loaded when the core is sampled, emptied when the backend acknowledges it.
module mmu_arbiter_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_wdata,
  output logic        valid,
  output logic [31:0] addr,
  output logic [31:0] wdata
);

  // Load takes the request and its operands; clear only drops the valid flag so the address stays readable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      wdata <= load_wdata;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mmu_arbiter.sv
// Serialises the core's write, data-read and instruction-read ports onto one backend request/ack port.
module mmu_arbiter
  import mmu_arbiter_pkg::*;
#(
  parameter int BACKEND_ADDR_WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          INST_RDEN,
  input  logic [31:0]                   INST_RIADDR,
  output logic [31:0]                   INST_ROADDR,
  output logic                          INST_RVALID,
  output logic [31:0]                   INST_RDATA,
  input  logic                          DATA_RDEN,
  input  logic [31:0]                   DATA_RIADDR,
  output logic [31:0]                   DATA_ROADDR,
  output logic                          DATA_RVALID,
  output logic [31:0]                   DATA_RDATA,
  input  logic                          DATA_WREN,
  input  logic [31:0]                   DATA_WADDR,
  input  logic [31:0]                   DATA_WDATA,
  output logic                          MEM_WAIT,
  output logic                          MEM_REQ,
  output logic                          MEM_WE,
  output logic [BACKEND_ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [31:0]                   MEM_WDATA,
  input  logic                          MEM_ACK,
  input  logic [31:0]                   MEM_RDATA
);

  arb_state_t         state;
  arb_state_t         next_state;
  logic               sampling;
  logic               ack;
  logic               next_busy;
  logic               svc_d;
  logic               svc_i;
  logic [NUM_SRC-1:0] slot_load;
  logic [NUM_SRC-1:0] slot_clear;
  logic [NUM_SRC-1:0] slot_valid;
  logic [NUM_SRC-1:0] pend_next;
  logic [31:0]        slot_addr  [NUM_SRC];
  logic [31:0]        slot_wdata [NUM_SRC];
  mem_txn_t           cand       [NUM_SRC];
  mem_txn_t           next_txn;

  assign sampling = (state == IDLE) || (state == DONE);
  assign ack      = MEM_REQ && MEM_ACK;

  assign slot_load[SRC_W]  = sampling && DATA_WREN;
  assign slot_load[SRC_D]  = sampling && DATA_RDEN;
  assign slot_load[SRC_I]  = sampling && INST_RDEN;
  assign slot_clear[SRC_W] = ack && (state == SERVE_W);
  assign slot_clear[SRC_D] = ack && (state == SERVE_D);
  assign slot_clear[SRC_I] = ack && (state == SERVE_I);

  mmu_arbiter_slot u_slot_w (
    .clk(CLK), .rst(RST), .load(slot_load[SRC_W]), .clear(slot_clear[SRC_W]),
    .load_addr(DATA_WADDR), .load_wdata(DATA_WDATA),
    .valid(slot_valid[SRC_W]), .addr(slot_addr[SRC_W]), .wdata(slot_wdata[SRC_W])
  );

  mmu_arbiter_slot u_slot_d (
    .clk(CLK), .rst(RST), .load(slot_load[SRC_D]), .clear(slot_clear[SRC_D]),
    .load_addr(DATA_RIADDR), .load_wdata(32'h0),
    .valid(slot_valid[SRC_D]), .addr(slot_addr[SRC_D]), .wdata(slot_wdata[SRC_D])
  );

  mmu_arbiter_slot u_slot_i (
    .clk(CLK), .rst(RST), .load(slot_load[SRC_I]), .clear(slot_clear[SRC_I]),
    .load_addr(INST_RIADDR), .load_wdata(32'h0),
    .valid(slot_valid[SRC_I]), .addr(slot_addr[SRC_I]), .wdata(slot_wdata[SRC_I])
  );

  // Work still owed after this edge: fresh core requests when sampling, otherwise the slots minus the one being acked
  always_comb begin
    pend_next          = slot_valid & ~slot_clear;
    cand[SRC_W].we     = 1'b1;
    cand[SRC_W].addr   = slot_addr[SRC_W];
    cand[SRC_W].wdata  = slot_wdata[SRC_W];
    cand[SRC_D].we     = 1'b0;
    cand[SRC_D].addr   = slot_addr[SRC_D];
    cand[SRC_D].wdata  = slot_wdata[SRC_D];
    cand[SRC_I].we     = 1'b0;
    cand[SRC_I].addr   = slot_addr[SRC_I];
    cand[SRC_I].wdata  = slot_wdata[SRC_I];
    if (sampling) begin
      pend_next[SRC_W]  = DATA_WREN;
      pend_next[SRC_D]  = DATA_RDEN;
      pend_next[SRC_I]  = INST_RDEN;
      cand[SRC_W].addr  = DATA_WADDR;
      cand[SRC_W].wdata = DATA_WDATA;
      cand[SRC_D].addr  = DATA_RIADDR;
      cand[SRC_D].wdata = 32'h0;
      cand[SRC_I].addr  = INST_RIADDR;
      cand[SRC_I].wdata = 32'h0;
    end
  end

  // Fixed priority pick: the write goes first so a same-sample read of that address sees the new data
  always_comb begin
    next_busy  = 1'b1;
    next_state = SERVE_W;
    next_txn   = cand[SRC_W];
    if (pend_next[SRC_W]) begin
      next_state = SERVE_W;
      next_txn   = cand[SRC_W];
    end else if (pend_next[SRC_D]) begin
      next_state = SERVE_D;
      next_txn   = cand[SRC_D];
    end else if (pend_next[SRC_I]) begin
      next_state = SERVE_I;
      next_txn   = cand[SRC_I];
    end else begin
      next_busy  = 1'b0;
      next_state = sampling ? IDLE : DONE;
    end
  end

  // FSM plus every registered output; it only moves on a sample edge or a backend acknowledge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      MEM_WAIT    <= 1'b0;
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_WDATA   <= '0;
      svc_d       <= 1'b0;
      svc_i       <= 1'b0;
      DATA_RVALID <= 1'b0;
      INST_RVALID <= 1'b0;
      DATA_RDATA  <= '0;
      DATA_ROADDR <= '0;
      INST_RDATA  <= '0;
      INST_ROADDR <= '0;
    end else begin
      if (sampling || ack) begin
        state    <= next_state;
        MEM_WAIT <= next_busy;
        MEM_REQ  <= next_busy;
        if (next_busy) begin
          MEM_WE    <= next_txn.we;
          MEM_ADDR  <= next_txn.addr[BACKEND_ADDR_WIDTH-1:0];
          MEM_WDATA <= next_txn.wdata;
        end
      end
      if (sampling) begin
        svc_d <= 1'b0;
        svc_i <= 1'b0;
      end
      if (slot_clear[SRC_D]) begin
        svc_d       <= 1'b1;
        DATA_RDATA  <= MEM_RDATA;
        DATA_ROADDR <= slot_addr[SRC_D];
      end
      if (slot_clear[SRC_I]) begin
        svc_i       <= 1'b1;
        INST_RDATA  <= MEM_RDATA;
        INST_ROADDR <= slot_addr[SRC_I];
      end
      DATA_RVALID <= ack && !next_busy && (svc_d || slot_clear[SRC_D]);
      INST_RVALID <= ack && !next_busy && (svc_i || slot_clear[SRC_I]);
    end
  end

endmodule

// File: tb/tb_mmu_arbiter.sv
// Self-checking bench for mmu_arbiter: table vectors, hand-written reset/idle sequences and randomized traffic.
module tb_mmu_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        wren;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        dren;
    logic [31:0] draddr;
    logic        iren;
    logic [31:0] iaddr;
    int          lat;
    int          exp_wait;
    logic        exp_dv;
    logic        exp_iv;
    logic [31:0] exp_d;
    logic [31:0] exp_i;
  } vec_t;

  logic        CLK;
  logic        RST;
  logic        INST_RDEN;
  logic [31:0] INST_RIADDR;
  logic [31:0] INST_ROADDR;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        DATA_RDEN;
  logic [31:0] DATA_RIADDR;
  logic [31:0] DATA_ROADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        DATA_WREN;
  logic [31:0] DATA_WADDR;
  logic [31:0] DATA_WDATA;
  logic        MEM_WAIT;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bk_mem    [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  txn_t        exp_q [$];
  txn_t        obs_q [$];
  int          lat_log [$];
  bit          rand_lat  = 1'b0;
  int          fixed_lat = 0;
  bit          busy      = 1'b0;
  int          cnt       = 0;
  int          lat       = 0;
  logic        hold_we;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;
  vec_t        vecs [6];

  mmu_arbiter #(.BACKEND_ADDR_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_ROADDR(INST_ROADDR),
    .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
    .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_ROADDR(DATA_ROADDR),
    .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
    .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WDATA(DATA_WDATA),
    .MEM_WAIT(MEM_WAIT), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Contents of memory locations nobody has written yet
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] bkRead(input logic [31:0] a);
    return bk_mem.exists(a) ? bk_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic req);
    checkOutput(name, {31'b0, act}, {31'b0, req});
  endtask

  // Backend memory: acks each request after a chosen latency and checks the request stays put meanwhile
  initial begin
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
    forever begin
      @(posedge CLK);
      #2;
      if (RST) begin
        busy      = 1'b0;
        MEM_ACK   = 1'b0;
        MEM_RDATA = $urandom;
      end else begin
        if (busy) begin
          checkFlag("mem_req_held", MEM_REQ, 1'b1);
          checkOutput("mem_addr_stable", MEM_ADDR, hold_addr);
          checkFlag("mem_we_stable", MEM_WE, hold_we);
        end else if (MEM_REQ) begin
          busy       = 1'b1;
          cnt        = 0;
          lat        = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
          lat_log.push_back(lat);
          hold_we    = MEM_WE;
          hold_addr  = MEM_ADDR;
          hold_wdata = MEM_WDATA;
        end
        if (busy && cnt == lat) begin
          txn_t t;
          t.we      = hold_we;
          t.addr    = hold_addr;
          t.wdata   = hold_wdata;
          obs_q.push_back(t);
          MEM_ACK   = 1'b1;
          MEM_RDATA = hold_we ? $urandom : bkRead(hold_addr);
          if (hold_we) bk_mem[hold_addr] = hold_wdata;
          busy      = 1'b0;
        end else begin
          MEM_ACK   = 1'b0;
          MEM_RDATA = $urandom;
          if (busy) cnt++;
        end
      end
    end
  end

  // Presents one sample, scribbles on the core inputs while stalled, then checks DONE and the backend order
  task automatic applyStimulus(input vec_t v, input bit use_model);
    txn_t        t;
    logic [31:0] md;
    logic [31:0] mi;
    logic [31:0] exp_d;
    logic [31:0] exp_i;
    logic        exp_dv;
    logic        exp_iv;
    int          exp_wait;
    int          waits;
    bit          done;
    exp_q.delete();
    obs_q.delete();
    lat_log.delete();
    md = 32'h0;
    mi = 32'h0;
    if (v.wren) begin
      t.we = 1'b1; t.addr = v.waddr; t.wdata = v.wdata;
      exp_q.push_back(t);
      model_mem[v.waddr] = v.wdata;
    end
    if (v.dren) begin
      t.we = 1'b0; t.addr = v.draddr; t.wdata = 32'h0;
      exp_q.push_back(t);
      md = modelRead(v.draddr);
    end
    if (v.iren) begin
      t.we = 1'b0; t.addr = v.iaddr; t.wdata = 32'h0;
      exp_q.push_back(t);
      mi = modelRead(v.iaddr);
    end
    rand_lat    = use_model;
    fixed_lat   = v.lat;
    DATA_WREN   = v.wren;
    DATA_WADDR  = v.waddr;
    DATA_WDATA  = v.wdata;
    DATA_RDEN   = v.dren;
    DATA_RIADDR = v.draddr;
    INST_RDEN   = v.iren;
    INST_RIADDR = v.iaddr;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge CLK);
      #1;
      if (MEM_WAIT) begin
        waits++;
        DATA_WREN   = 1'($urandom_range(0, 1));
        DATA_WADDR  = $urandom;
        DATA_WDATA  = $urandom;
        DATA_RDEN   = 1'($urandom_range(0, 1));
        DATA_RIADDR = $urandom;
        INST_RDEN   = 1'($urandom_range(0, 1));
        INST_RIADDR = $urandom;
      end else begin
        done      = 1'b1;
        DATA_WREN = 1'b0;
        DATA_RDEN = 1'b0;
        INST_RDEN = 1'b0;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL stall_timeout: MEM_WAIT still 1 after 200 cycles, required 0");
    end else begin
      if (use_model) begin
        exp_wait = 0;
        foreach (lat_log[i]) exp_wait += lat_log[i] + 1;
        exp_dv = v.dren;
        exp_iv = v.iren;
        exp_d  = md;
        exp_i  = mi;
      end else begin
        exp_wait = v.exp_wait;
        exp_dv   = v.exp_dv;
        exp_iv   = v.exp_iv;
        exp_d    = v.exp_d;
        exp_i    = v.exp_i;
      end
      checkOutput("wait_cycles", 32'(waits), 32'(exp_wait));
      checkFlag("done_mem_req", MEM_REQ, 1'b0);
      checkFlag("done_data_rvalid", DATA_RVALID, exp_dv);
      checkFlag("done_inst_rvalid", INST_RVALID, exp_iv);
      if (exp_dv) begin
        checkOutput("data_rdata", DATA_RDATA, exp_d);
        checkOutput("data_roaddr", DATA_ROADDR, v.draddr);
      end
      if (exp_iv) begin
        checkOutput("inst_rdata", INST_RDATA, exp_i);
        checkOutput("inst_roaddr", INST_ROADDR, v.iaddr);
      end
      checkOutput("txn_count", 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checkFlag("txn_we", obs_q[i].we, exp_q[i].we);
        checkOutput("txn_addr", obs_q[i].addr, exp_q[i].addr);
        if (exp_q[i].we) checkOutput("txn_wdata", obs_q[i].wdata, exp_q[i].wdata);
      end
      @(posedge CLK);
      #1;
      checkOutput("after_done_rvalid", {30'b0, DATA_RVALID, INST_RVALID}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required $finish before it");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1;
    INST_RDEN = 1'b0; INST_RIADDR = 32'h0;
    DATA_RDEN = 1'b0; DATA_RIADDR = 32'h0;
    DATA_WREN = 1'b0; DATA_WADDR = 32'h0; DATA_WDATA = 32'h0;

    bk_mem[32'h100]    = 32'h0000_0013;
    bk_mem[32'h0]      = 32'h0000_0093;
    bk_mem[32'h300]    = 32'h1234_5678;
    model_mem[32'h100] = 32'h0000_0013;
    model_mem[32'h0]   = 32'h0000_0093;
    model_mem[32'h300] = 32'h1234_5678;

    vecs[0] = '{wren:1'b0, waddr:32'h0, wdata:32'h0, dren:1'b0, draddr:32'h0,
                iren:1'b1, iaddr:32'h100, lat:0, exp_wait:1,
                exp_dv:1'b0, exp_iv:1'b1, exp_d:32'h0, exp_i:32'h0000_0013};
    vecs[1] = '{wren:1'b1, waddr:32'h200, wdata:32'hDEAD_BEEF, dren:1'b1, draddr:32'h200,
                iren:1'b1, iaddr:32'h0, lat:0, exp_wait:3,
                exp_dv:1'b1, exp_iv:1'b1, exp_d:32'hDEAD_BEEF, exp_i:32'h0000_0093};
    vecs[2] = '{wren:1'b0, waddr:32'h0, wdata:32'h0, dren:1'b1, draddr:32'h300,
                iren:1'b0, iaddr:32'h0, lat:3, exp_wait:4,
                exp_dv:1'b1, exp_iv:1'b0, exp_d:32'h1234_5678, exp_i:32'h0};
    vecs[3] = '{wren:1'b0, waddr:32'h0, wdata:32'h0, dren:1'b0, draddr:32'h0,
                iren:1'b0, iaddr:32'h0, lat:0, exp_wait:0,
                exp_dv:1'b0, exp_iv:1'b0, exp_d:32'h0, exp_i:32'h0};
    vecs[4] = '{wren:1'b1, waddr:32'h400, wdata:32'hCAFE_F00D, dren:1'b0, draddr:32'h0,
                iren:1'b0, iaddr:32'h0, lat:1, exp_wait:2,
                exp_dv:1'b0, exp_iv:1'b0, exp_d:32'h0, exp_i:32'h0};
    vecs[5] = '{wren:1'b0, waddr:32'h0, wdata:32'h0, dren:1'b1, draddr:32'h400,
                iren:1'b1, iaddr:32'h300, lat:2, exp_wait:6,
                exp_dv:1'b1, exp_iv:1'b1, exp_d:32'hCAFE_F00D, exp_i:32'h1234_5678};

    repeat (3) @(posedge CLK);
    #1;
    checkFlag("rst_mem_wait", MEM_WAIT, 1'b0);
    checkFlag("rst_mem_req", MEM_REQ, 1'b0);
    checkFlag("rst_mem_we", MEM_WE, 1'b0);
    checkOutput("rst_mem_addr", MEM_ADDR, 32'h0);
    checkOutput("rst_mem_wdata", MEM_WDATA, 32'h0);
    checkOutput("rst_rvalids", {30'b0, DATA_RVALID, INST_RVALID}, 32'h0);
    checkOutput("rst_inst_roaddr", INST_ROADDR, 32'h0);
    checkOutput("rst_inst_rdata", INST_RDATA, 32'h0);
    checkOutput("rst_data_roaddr", DATA_ROADDR, 32'h0);
    checkOutput("rst_data_rdata", DATA_RDATA, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 1'b0);

    $display("[TB] idle core for 10 cycles");
    for (int c = 0; c < 10; c++) begin
      INST_RIADDR = $urandom;
      DATA_RIADDR = $urandom;
      @(posedge CLK);
      #1;
      checkOutput("idle_outputs", {28'b0, MEM_REQ, MEM_WAIT, DATA_RVALID, INST_RVALID}, 32'h0);
    end

    $display("[TB] reset during a data read");
    rand_lat    = 1'b0;
    fixed_lat   = 20;
    DATA_RDEN   = 1'b1;
    DATA_RIADDR = 32'h500;
    @(posedge CLK);
    #1;
    DATA_RDEN = 1'b0;
    checkFlag("rst_mid_wait_before", MEM_WAIT, 1'b1);
    @(posedge CLK);
    #1;
    checkFlag("rst_mid_req_before", MEM_REQ, 1'b1);
    checkOutput("rst_mid_addr_before", MEM_ADDR, 32'h500);
    #2;
    RST = 1'b1;
    #1;
    checkFlag("rst_mid_req_async", MEM_REQ, 1'b0);
    checkFlag("rst_mid_wait_async", MEM_WAIT, 1'b0);
    checkFlag("rst_mid_dvalid_async", DATA_RVALID, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checkFlag("rst_mid_wait_after", MEM_WAIT, 1'b0);
    checkFlag("rst_mid_req_after", MEM_REQ, 1'b0);
    applyStimulus(vecs[0], 1'b0);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 40; r++) begin
      vec_t v;
      v.wren     = 1'($urandom_range(0, 1));
      v.waddr    = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      v.wdata    = $urandom;
      v.dren     = 1'($urandom_range(0, 1));
      v.draddr   = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      v.iren     = 1'($urandom_range(0, 1));
      v.iaddr    = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      v.lat      = 0;
      v.exp_wait = 0;
      v.exp_dv   = 1'b0;
      v.exp_iv   = 1'b0;
      v.exp_d    = 32'h0;
      v.exp_i    = 32'h0;
      applyStimulus(v, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_arbiter.md
# mmu_arbiter

Memory-side responder for the core's three memory ports: instruction read, data read and data write. It captures the requests the core presents in a cycle and serialises them onto one backing-memory request/acknowledge port. It holds the core stalled through MEM_WAIT until every captured request is serviced, then returns the read results. It sits between the core and the on-chip memory or bus bridge.

## Interface
Parameters:
- BACKEND_ADDR_WIDTH, default 32: width of MEM_ADDR; carries bits [BACKEND_ADDR_WIDTH-1:0] of the core byte address.

Ports:
- CLK  in  1  clock; single clock domain
- RST  in  1  asynchronous, active-high reset
- INST_RDEN  in  1  instruction read request
- INST_RIADDR  in  32  instruction read address
- INST_ROADDR  out  32  address the returned instruction belongs to
- INST_RVALID  out  1  INST_RDATA/INST_ROADDR valid
- INST_RDATA  out  32  instruction word
- DATA_RDEN  in  1  data read request
- DATA_RIADDR  in  32  data read address
- DATA_ROADDR  out  32  address the returned data belongs to
- DATA_RVALID  out  1  DATA_RDATA/DATA_ROADDR valid
- DATA_RDATA  out  32  data word
- DATA_WREN  in  1  data write request
- DATA_WADDR  in  32  write address
- DATA_WDATA  in  32  write data
- MEM_WAIT  out  1  core stall; registered
- MEM_REQ  out  1  backend request
- MEM_WE  out  1  backend write (1) / read (0)
- MEM_ADDR  out  BACKEND_ADDR_WIDTH  backend address
- MEM_WDATA  out  32  backend write data
- MEM_ACK  in  1  backend completion; may be high in the same cycle MEM_REQ first rises
- MEM_RDATA  in  32  backend read data, valid when MEM_REQ && MEM_ACK

## Operation
- Sample cycle: any cycle with MEM_WAIT=0.
  - On its closing edge, each asserted request (write, data read, instruction read) is latched with its address and data into a pending slot.
  - Core inputs are ignored while MEM_WAIT=1.
- MEM_WAIT = OR of pending slots, driven from state registers. No requests sampled → MEM_WAIT stays 0.
- Fixed service priority: write > data read > instruction read. A read and a write to the same address in one sample therefore return the newly written data.
- FSM states: IDLE, SERVE_W, SERVE_D, SERVE_I, DONE.
  - IDLE → highest-priority pending SERVE_x after a sample edge with at least one request.
  - SERVE_x: MEM_REQ=1 with MEM_WE, MEM_ADDR and MEM_WDATA stable until MEM_REQ && MEM_ACK.
  - On ACK: the slot clears; for reads, MEM_RDATA and the slot address are captured into the output registers.
  - After ACK, go to the next pending SERVE_x, or to DONE if no slot is pending.
  - DONE: MEM_WAIT=0, MEM_REQ=0; return to IDLE and sample on this cycle's edge.
- RVALID: high only in the DONE cycle, and only for ports whose read was serviced. Otherwise 0.
- RDATA/ROADDR: hold their last captured value.
- Reset mid-transfer: MEM_REQ drops immediately and all slots clear. The backend tolerates an abandoned request.

## Timing
- Reset values: MEM_WAIT=0, INST_RVALID=0, DATA_RVALID=0, all ROADDR/RDATA=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0. State is IDLE.
- For k requests sampled in cycle N, with each backend ACK arriving a_i cycles after its MEM_REQ:
  - MEM_WAIT=1 from cycle N+1 through the last ACK cycle.
  - DONE and RVALID occur one cycle after the last ACK.
  - With zero-latency ACK (a_i=0) the total is k wait cycles; DONE is in N+k+1.
- MEM_REQ is contiguous between back-to-back transactions; MEM_ADDR changes on the ACK edge.
- Only one backend transaction is outstanding at any time.

## Structure
- Package mmu_arbiter_pkg:
  - FSM state typedef.
  - Source-select constants SRC_W, SRC_D, SRC_I.
  - Backend transaction struct {we, addr, wdata}.
- Sub-module mmu_arbiter_slot: a pending register (valid, addr, wdata), one instance per source, with load-on-sample and clear-on-ACK.

## Test plan
- Reset mid-SERVE_D with MEM_REQ=1: MEM_REQ, MEM_WAIT and RVALID go 0 asynchronously; after release, IDLE and MEM_WAIT=0.
- INST_RDEN only, addr 0x100, backend returns 0x00000013 with ACK same cycle:
  - MEM_WAIT high for 1 cycle.
  - Next cycle INST_RVALID=1, INST_ROADDR=0x100, INST_RDATA=0x13.
- Write 0x200←0xDEADBEEF plus data read 0x200 plus inst read 0x0 in one sample:
  - Backend sees W 0x200, then R 0x200, then R 0x0.
  - DATA_RDATA=0xDEADBEEF; both RVALIDs high together.
- Backend ACK delayed 3 cycles on a data read: MEM_ADDR and MEM_REQ stay stable for 4 cycles; MEM_WAIT=1 for 4 cycles.
- Core changes INST_RIADDR while MEM_WAIT=1: ignored; the serviced address is the sampled one.
- Idle core, no requests for 10 cycles: MEM_REQ=0, MEM_WAIT=0 and both RVALID=0 throughout.
